// File: rtl/aes_pkg.sv
// Shared widths and types for the AES datapath block FIFO and its narrow output bus.
package aes_pkg;

  localparam int unsigned BLOCK_WIDTH = 128;
  localparam int unsigned WORD_WIDTH  = 32;
  localparam int unsigned BEATS       = BLOCK_WIDTH / WORD_WIDTH;

  typedef logic [BLOCK_WIDTH-1:0] block_t;
  typedef logic [WORD_WIDTH-1:0]  word_t;

  // Counter width able to index n items, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO pop side plus serialized output stream; master is the reader, slave its environment.
interface fifo_stream_reader_if
  import aes_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = BLOCK_WIDTH,
  parameter int unsigned OUT_WIDTH  = WORD_WIDTH
);

  logic                  fifo_empty_i;
  logic                  fifo_pop_o;
  logic [DATA_WIDTH-1:0] fifo_data_i;
  logic                  flush_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [OUT_WIDTH-1:0]  out_data_o;
  logic                  out_last_o;
  logic                  busy_o;

  modport master (
    input  fifo_empty_i, fifo_data_i, flush_i, out_ready_i,
    output fifo_pop_o, out_valid_o, out_data_o, out_last_o, busy_o
  );

  modport slave (
    output fifo_empty_i, fifo_data_i, flush_i, out_ready_i,
    input  fifo_pop_o, out_valid_o, out_data_o, out_last_o, busy_o
  );

endinterface

// File: rtl/block_buf2.sv
// Two-entry block buffer: write at tail, release head, occupancy 0..2.
module block_buf2
  import aes_pkg::*;
#(
  parameter int unsigned WIDTH = BLOCK_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             free,
  output logic [1:0]       occ,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] mem [2];
  logic             head;
  logic             tail;

  // Storage itself is never cleared; consumers gate it with occupancy.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      occ  <= 2'd0;
      head <= 1'b0;
      tail <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[tail] <= wr_data;
        tail      <= ~tail;
      end
      if (free) begin
        head <= ~head;
      end
      occ <= occ + 2'(wr_en) - 2'(free);
    end
  end

  assign head_data = mem[head];

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops blocks from the synchronous FIFO, absorbs its read latency in a 2-entry buffer,
// and serializes each block MSB word first onto a valid/ready stream with last.
module fifo_stream_reader
  import aes_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = BLOCK_WIDTH,
  parameter int unsigned OUT_WIDTH  = WORD_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_stream_reader_if.master bus
);

  localparam int unsigned    BEATS     = DATA_WIDTH / OUT_WIDTH;
  localparam int unsigned    BW        = cnt_width(BEATS);
  localparam logic [BW-1:0]  LAST_BEAT = BW'(BEATS - 1);

  logic                  inflight;
  logic [BW-1:0]         beat;
  logic [1:0]            occ;
  logic [DATA_WIDTH-1:0] head_data;

  logic                  valid_c;
  logic                  last_c;
  logic                  xfer_c;
  logic                  free_c;
  logic                  pop_c;
  logic [OUT_WIDTH-1:0]  data_c;

  assign valid_c = (occ != 2'd0);
  assign last_c  = valid_c && (beat == LAST_BEAT);
  assign xfer_c  = valid_c && bus.out_ready_i;
  assign free_c  = xfer_c && last_c;

  // Pop only if the block can land in a slot: held + in flight - leaving stays below 2.
  assign pop_c = !rst && !bus.flush_i && !bus.fifo_empty_i &&
                 ((3'(occ) + 3'(inflight)) < (3'd2 + 3'(free_c)));

  always_comb begin
    data_c = '0;
    if (valid_c) begin
      data_c = OUT_WIDTH'(head_data >> ((BEATS - 1 - 32'(beat)) * OUT_WIDTH));
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush_i) begin
      inflight <= 1'b0;
      beat     <= '0;
    end else begin
      inflight <= pop_c;
      if (xfer_c) begin
        beat <= last_c ? '0 : beat + 1'b1;
      end
    end
  end

  // Capture is keyed on inflight alone; data content never implies validity.
  block_buf2 #(
    .WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.flush_i),
    .wr_en     (inflight),
    .wr_data   (bus.fifo_data_i),
    .free      (free_c),
    .occ       (occ),
    .head_data (head_data)
  );

  assign bus.fifo_pop_o  = pop_c;
  assign bus.out_valid_o = valid_c;
  assign bus.out_data_o  = data_c;
  assign bus.out_last_o  = last_c;
  assign bus.busy_o      = valid_c || inflight;

endmodule
